// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad encoder
// Purpose : state encoding, key indices and the priority encoder used by keypad_encoder.
// Ports   : none (package).
// Config  : KEYPAD_REPEAT_EN is consumed by keypad_encoder, not by this package.
package keypad_pkg;

   localparam int         NUM_KEYS = 18;
   localparam logic [4:0] KEY_BKSP = 5'd16;
   localparam logic [4:0] KEY_CLR  = 5'd17;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DEBOUNCE = 3'd1,
      EMIT     = 3'd2,
      HOLD     = 3'd3,
      RELEASE  = 3'd4
   } state_t;

   // Highest set index wins, so clear beats backspace beats F down to 0.
   function automatic logic [4:0] prio_enc(input logic [NUM_KEYS-1:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (v[i]) begin
            idx = 5'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - parameterised-width two-flop synchroniser
// Purpose : bring asynchronous levels into the clk domain.
// Ports   : clk, rst_n (async active-low), d [WIDTH-1:0] raw in, q [WIDTH-1:0] synchronised out.
// Config  : no build macros.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - debounced priority keypad encoder, one strobe per press
// Purpose : synchronise and debounce 18 push buttons, emit one formatted strobe per press.
// Ports   : clk; rst (async active-low); pb [19:0] raw buttons ([15:0] hex, 16 bksp, 17 clr, [19:18] unused);
//           strobe, in_char [3:0], is_ctrl, bksp, clr - registered, asserted only in EMIT.
// Config  : define KEYPAD_REPEAT_EN to enable auto-repeat of held hex/backspace keys.
module keypad_encoder
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] pb,
   output logic        strobe,
   output logic [3:0]  in_char,
   output logic        is_ctrl,
   output logic        bksp,
   output logic        clr
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] pb_sync;
   logic                any_key;
   logic [1:0]          unused_pb;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [4:0] key_q, key_d;

   logic       strobe_q, strobe_d;
   logic [3:0] in_char_q, in_char_d;
   logic       is_ctrl_q, is_ctrl_d;
   logic       bksp_q, bksp_d;
   logic       clr_q, clr_d;

`ifdef KEYPAD_REPEAT_EN
   localparam logic [15:0] REP_FIRST = 16'(REPEAT_DELAY - 1);
   localparam logic [15:0] REP_NEXT  = 16'(REPEAT_PERIOD - 1);

   logic [15:0] rep_cnt_q, rep_cnt_d;
   // Set after the debounced strobe so the first repeat waits the longer delay.
   logic        rep_first_q, rep_first_d;
   logic [15:0] rep_last;
   logic        rep_ok;

   assign rep_last = rep_first_q ? REP_FIRST : REP_NEXT;
   assign rep_ok   = pb_sync[key_q] && (key_q != KEY_CLR);
`else
   localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

   assign unused_pb = pb[19:18];

   sync2 #(.WIDTH(NUM_KEYS)) u_sync (
      .clk   (clk),
      .rst_n (rst),
      .d     (pb[NUM_KEYS-1:0]),
      .q     (pb_sync)
   );

   assign any_key = |pb_sync;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_key) begin
               state_d = DEBOUNCE;
               cnt_d   = '0;
               key_d   = prio_enc(pb_sync);
            end
         end
         DEBOUNCE: begin
            // Only the captured key matters; other keys cannot keep a bounce alive.
            if (!pb_sync[key_q]) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = EMIT;
`ifdef KEYPAD_REPEAT_EN
               rep_first_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         EMIT: begin
            state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d = '0;
`endif
         end
         HOLD: begin
            if (!any_key) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_ok) begin
               if (rep_cnt_q == rep_last) begin
                  state_d     = EMIT;
                  rep_first_d = 1'b0;
               end else begin
                  rep_cnt_d = rep_cnt_q + 16'd1;
               end
            end else begin
               rep_cnt_d = '0;
            end
`endif
         end
         RELEASE: begin
            if (any_key) begin
               state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
               rep_cnt_d = '0;
`endif
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so they are
   // glitch-free flop outputs that are high exactly while state_q is EMIT.
   always_comb begin
      strobe_d  = (state_d == EMIT);
      in_char_d = '0;
      is_ctrl_d = 1'b0;
      bksp_d    = 1'b0;
      clr_d     = 1'b0;
      if (state_d == EMIT) begin
         if (!key_d[4]) begin
            in_char_d = key_d[3:0];
         end else begin
            is_ctrl_d = 1'b1;
            bksp_d    = (key_d == KEY_BKSP);
            clr_d     = (key_d == KEY_CLR);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         key_q     <= '0;
         strobe_q  <= 1'b0;
         in_char_q <= '0;
         is_ctrl_q <= 1'b0;
         bksp_q    <= 1'b0;
         clr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         key_q     <= key_d;
         strobe_q  <= strobe_d;
         in_char_q <= in_char_d;
         is_ctrl_q <= is_ctrl_d;
         bksp_q    <= bksp_d;
         clr_q     <= clr_d;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
      end
   end
`endif

   assign strobe  = strobe_q;
   assign in_char = in_char_q;
   assign is_ctrl = is_ctrl_q;
   assign bksp    = bksp_q;
   assign clr     = clr_q;

endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Upstream stage of the character buffer. Accepts raw push-button levels, synchronises and debounces them, and priority-encodes one key per press.
- Emits exactly one single-cycle strobe per accepted press, with in_char, is_ctrl, bksp and clr formatted to drive the buffer's enable, in_char, is_ctrl, bksp and clr inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a press, and also to accept a release. Legal range 1..255.
- REPEAT_DELAY, 16: cycles a key must be held before the first auto-repeat. Used only with KEYPAD_REPEAT_EN.
- REPEAT_PERIOD, 8: cycles between successive auto-repeats. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- pb  in  20  raw, asynchronous button levels.
  - pb[15:0] = hex digits 0x0..0xF.
  - pb[16] = backspace.
  - pb[17] = clear.
  - pb[19:18] = ignored.
- strobe  out  1  one-cycle pulse per accepted key; drives the buffer's enable.
- in_char  out  4  digit value for hex keys; 0 for control keys.
- is_ctrl  out  1  1 for backspace and clear events.
- bksp  out  1  1 alongside strobe for a backspace event.
- clr  out  1  1 alongside strobe for a clear event.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst.
- Reset values: while rst=0, all outputs are 0, the state is IDLE, the synchroniser flops and counters are 0, and the captured key is 0.
- Synchroniser: pb passes through a 2-flop synchroniser to form pb_sync. any_key is the OR of pb_sync[17:0].
- Priority: the highest index among pb_sync[17:0] wins (clear > backspace > F > ... > 0). The winning 5-bit key index is captured on leaving IDLE.
- IDLE:
  - any_key=1 → DEBOUNCE, counter cleared to 0.
- DEBOUNCE:
  - Captured key's pb_sync bit = 0 → IDLE (bounce rejected, nothing emitted).
  - Else if counter = DEBOUNCE_CYCLES-1 → EMIT.
  - Else counter increments.
- EMIT (exactly one cycle):
  - strobe=1.
  - Hex key: in_char = index, is_ctrl=0, bksp=0, clr=0.
  - Backspace: in_char=0, is_ctrl=1, bksp=1.
  - Clear: in_char=0, is_ctrl=1, clr=1.
  - Next state: HOLD.
- HOLD:
  - Outputs are 0.
  - any_key=0 → RELEASE, counter cleared.
- RELEASE:
  - any_key=1 → HOLD.
  - Counter = DEBOUNCE_CYCLES-1 → IDLE.
  - Else counter increments.
- Outputs are a Moore decode of the registered state plus the captured index. They are glitch-free and never asserted outside EMIT.
- Latency: count the first rising edge that samples pb high as edge 1. strobe is high in the cycle following edge DEBOUNCE_CYCLES+3 (edge 7 at the default).
- Held and pressed keys:
  - A held key never produces a second strobe (repeat disabled).
  - Keys pressed while in HOLD or RELEASE are ignored until all keys are released and IDLE is reached.
- Simultaneous keys: if several keys are high in the same cycle, only the highest-priority key is captured. The lower-priority keys are absorbed by HOLD.
- Reset mid-operation: rst=0 in any state aborts immediately with no strobe. After rst returns to 1, a still-held key is a new press: full synchroniser and debounce latency applies.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in HOLD, a repeat counter runs while the captured key stays high.
  - After REPEAT_DELAY cycles in HOLD, the block returns through EMIT (one strobe with identical outputs). It then re-emits every REPEAT_PERIOD cycles while the key is held.
  - Repeat applies to hex keys and backspace only; clear never repeats.
  - Release of the captured key stops repeating at once.
- Undefined: no repeat counter or logic exists; HOLD behaves exactly as above.

Decomposition:
- keypad_pkg holds:
  - state enum (IDLE, DEBOUNCE, EMIT, HOLD, RELEASE);
  - constants KEY_BKSP=5'd16 and KEY_CLR=5'd17;
  - NUM_KEYS=18.
- One sub-module, sync2: a parameterised-width 2-flop synchroniser with async active-low reset. It is instantiated once for pb[17:0].

Test Plan:
- Reset: rst=0 with pb[5]=1 → all outputs 0 throughout. Release rst, hold pb[5] → strobe=1, in_char=4'h5, is_ctrl=0 once, in the cycle after edge 7.
- Bounce: pb[3] high 2 cycles, low, then high 2 cycles → no strobe. Then pb[3] held for 10 cycles → exactly one strobe with in_char=4'h3.
- Control keys:
  - pb[16] held → one strobe with is_ctrl=1, bksp=1, in_char=0.
  - Release, then pb[17] → one strobe with is_ctrl=1, clr=1.
- Priority: pb[2] and pb[9] rise in the same cycle → one strobe, in_char=4'h9. Holding both for 40 cycles gives no further strobes.
- Release debounce: after a 4'hA strobe, release pb[10] for 2 cycles, then re-press → no strobe. Release ≥4 cycles, then re-press → new strobe.
- KEYPAD_REPEAT_EN: hold pb[7] for 50 cycles → strobes at the base time, then +17, +26, +35, +44 cycles (first repeat after 16 cycles in HOLD, then every 8 cycles). Hold pb[17] → exactly one strobe.
